// File: rtl/lsu.sv
// Load/store unit: decodes ALU addresses into data memory or the fifo_if register
// window, performs B/H/W accesses with RV32 extension and returns data or a fault.
module lsu #(
  parameter int unsigned DMEM_WORDS = 1024,
  parameter logic [31:0] DMEM_BASE  = 32'h0001_0000,
  parameter logic [31:0] MMIO_BASE  = 32'h0002_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_fault_o,
  output logic        fifo_sel_o,
  output logic        fifo_rd_o,
  output logic        fifo_wr_o,
  output logic [1:0]  fifo_addr_o,
  output logic [7:0]  fifo_wdata_o,
  input  logic [7:0]  fifo_rdata_i
);

  localparam int unsigned IDX_W      = $clog2(DMEM_WORDS);
  localparam int unsigned AW         = IDX_W + 2;
  localparam logic [32:0] DMEM_BYTES = 33'(DMEM_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state_q, state_d;

  logic          we_q;
  logic [2:0]    funct3_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          mmio_q;
  logic          fault_q;
  logic [7:0]    mmio_rd_q;
  logic [31:0]   dmem_rd;
  logic [31:0]   mem [DMEM_WORDS];

  logic [31:0] dmem_off, mmio_off;
  logic        in_dmem, in_mmio, byte_op, size_bad, align_bad, req_fault;
  logic        accept, dmem_en;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;

  // Request decode; offsets are compared after subtraction so the upper bound cannot wrap
  always_comb begin
    dmem_off  = req_addr_i - DMEM_BASE;
    mmio_off  = req_addr_i - MMIO_BASE;
    in_dmem   = (req_addr_i >= DMEM_BASE) && ({1'b0, dmem_off} < DMEM_BYTES);
    in_mmio   = (req_addr_i >= MMIO_BASE) && (mmio_off < 32'd4);
    byte_op   = (req_funct3_i == 3'd0) || (req_funct3_i == 3'd4);
    size_bad  = 1'b0;
    align_bad = 1'b0;
    case (req_funct3_i)
      3'd0: size_bad = 1'b0;
      3'd4: size_bad = req_we_i;
      3'd1: align_bad = req_addr_i[0];
      3'd5: begin
        size_bad  = req_we_i;
        align_bad = req_addr_i[0];
      end
      3'd2: align_bad = |req_addr_i[1:0];
      default: size_bad = 1'b1;
    endcase
    req_fault = size_bad | align_bad | ~(in_dmem | in_mmio) | (in_mmio & ~byte_op);
  end

  assign accept  = (state_q == IDLE) && req_valid_i;
  assign dmem_en = (state_q == ACCESS) && !mmio_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = req_fault ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request payload, captured on the acceptance edge
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      mmio_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else if (accept) begin
      we_q     <= req_we_i;
      funct3_q <= req_funct3_i;
      addr_q   <= req_addr_i[AW-1:0];
      wdata_q  <= req_wdata_i;
      mmio_q   <= in_mmio;
      fault_q  <= req_fault;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                            mmio_rd_q <= 8'd0;
    else if (state_q == ACCESS && mmio_q)   mmio_rd_q <= fifo_rdata_i;
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    case (funct3_q[1:0])
      2'd0: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

  // Data memory is not reset; contents survive rstn_i
  always_ff @(posedge clk_i) begin
    if (dmem_en) begin
      if (we_q) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr_q[AW-1:2]][8*b +: 8] <= wlane[8*b +: 8];
        end
      end
      dmem_rd <= mem[addr_q[AW-1:2]];
    end
  end

  // Load lane select and extension; the fifo byte is already its own lane
  always_comb begin
    word   = mmio_q ? {24'd0, mmio_rd_q} : dmem_rd;
    byte_v = mmio_q ? mmio_rd_q : word[{addr_q[1:0], 3'b000} +: 8];
    half_v = word[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    load_ext = {{24{byte_v[7]}}, byte_v};
      3'd4:    load_ext = {24'd0, byte_v};
      3'd1:    load_ext = {{16{half_v[15]}}, half_v};
      3'd5:    load_ext = {16'd0, half_v};
      default: load_ext = word;
    endcase
  end

  always_comb begin
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_fault_o  = 1'b0;
    rsp_rdata_o  = 32'd0;
    fifo_sel_o   = 1'b0;
    fifo_rd_o    = 1'b0;
    fifo_wr_o    = 1'b0;
    fifo_addr_o  = 2'd0;
    fifo_wdata_o = 8'd0;
    case (state_q)
      IDLE: req_ready_o = 1'b1;
      ACCESS: begin
        if (mmio_q) begin
          fifo_sel_o   = 1'b1;
          fifo_addr_o  = addr_q[1:0];
          fifo_wr_o    = we_q;
          fifo_rd_o    = !we_q;
          fifo_wdata_o = we_q ? wdata_q[7:0] : 8'd0;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_fault_o = fault_q;
        if (!fault_q && !we_q) rsp_rdata_o = load_ext;
      end
      default: req_ready_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and random requests checked against a byte-addressed
// reference memory and a queue of expected responses.
module tb_lsu;

  localparam logic [31:0] DB = 32'h0001_0000;
  localparam logic [31:0] MB = 32'h0002_0000;
  localparam int unsigned DW = 1024;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_fault_o;
  logic        fifo_sel_o;
  logic        fifo_rd_o;
  logic        fifo_wr_o;
  logic [1:0]  fifo_addr_o;
  logic [7:0]  fifo_wdata_o;
  logic [7:0]  fifo_rdata_i;

  lsu #(.DMEM_WORDS(DW), .DMEM_BASE(DB), .MMIO_BASE(MB)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_fault_o(rsp_fault_o),
    .fifo_sel_o(fifo_sel_o), .fifo_rd_o(fifo_rd_o), .fifo_wr_o(fifo_wr_o),
    .fifo_addr_o(fifo_addr_o), .fifo_wdata_o(fifo_wdata_o), .fifo_rdata_i(fifo_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          acc;
    int          lat;
    bit          fault;
    logic [31:0] rd;
    bit          mmio;
    bit          we;
    logic [1:0]  fa;
    logic [7:0]  fw;
    int          nstb;
  } exp_t;

  exp_t        q[$];
  byte unsigned mb[int unsigned];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  logic [31:0] last_rd;
  logic        last_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, fault rules and RV32 extension
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [7:0] fin,
                                output bit fault, output logic [31:0] rd, output bit mmio);
    longint unsigned la;
    int sz;
    bit in_d, in_m;
    logic [31:0] v;
    la   = 64'(a);
    in_d = (la >= 64'(DB)) && (la < 64'(DB) + 64'(4 * DW));
    in_m = (la >= 64'(MB)) && (la < 64'(MB) + 64'd4);
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    mmio  = in_m;
    rd    = 32'd0;
    fault = (sz == 0) || (we && f3 >= 3'd4) || !(in_d || in_m) || (in_m && sz != 1);
    if (sz != 0 && (la % 64'(sz)) != 0) fault = 1'b1;
    if (fault) return;
    if (we) begin
      if (in_d) for (int i = 0; i < sz; i++) mb[a + 32'(i)] = wd[8*i +: 8];
      return;
    end
    v = 32'd0;
    if (in_m) v = {24'd0, fin};
    else for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[a + 32'(i)];
    case (f3)
      3'd0:    rd = {{24{v[7]}}, v[7:0]};
      3'd4:    rd = {24'd0, v[7:0]};
      3'd1:    rd = {{16{v[15]}}, v[15:0]};
      3'd5:    rd = {16'd0, v[15:0]};
      default: rd = v;
    endcase
  endfunction

  task automatic drive(input bit v, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bit f, m;
    logic [31:0] r;
    req_valid_i  = v;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = a;
    req_wdata_i  = wd;
    if (v && req_ready_o && rstn_i) begin
      model(we, f3, a, wd, fifo_rdata_i, f, r, m);
      e.acc = cyc; e.lat = f ? 1 : 2; e.fault = f; e.rd = r; e.mmio = m;
      e.we = we; e.fa = a[1:0]; e.fw = wd[7:0]; e.nstb = 0;
      q.push_back(e);
    end
  endtask

  // One cycle of observation at the falling edge
  task automatic tick();
    exp_t e;
    @(negedge clk_i);
    cyc++;
    chk("ready", 32'(req_ready_o), 32'(q.size() == 0));
    if (fifo_sel_o) begin
      if (q.size() == 0) chk("stb_orphan", 32'(fifo_sel_o), 32'd0);
      else begin
        q[0].nstb = q[0].nstb + 1;
        chk("fifo_wr", 32'(fifo_wr_o), 32'(q[0].we));
        chk("fifo_rd", 32'(fifo_rd_o), 32'(!q[0].we));
        chk("fifo_addr", 32'(fifo_addr_o), 32'(q[0].fa));
        chk("fifo_wdata", 32'(fifo_wdata_o), q[0].we ? 32'(q[0].fw) : 32'd0);
      end
    end else begin
      chk("fifo_idle", 32'({fifo_rd_o, fifo_wr_o, fifo_addr_o, fifo_wdata_o}), 32'd0);
    end
    if (rsp_valid_o) begin
      if (q.size() == 0) chk("rsp_orphan", 32'(rsp_valid_o), 32'd0);
      else begin
        e = q.pop_front();
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("fault", 32'(rsp_fault_o), 32'(e.fault));
        chk("rdata", rsp_rdata_o, e.rd);
        chk("strobes", 32'(e.nstb), (e.mmio && !e.fault) ? 32'd1 : 32'd0);
        last_rd    = rsp_rdata_o;
        last_fault = rsp_fault_o;
      end
    end else begin
      chk("rdata_idle", rsp_rdata_o, 32'd0);
    end
  endtask

  task automatic req1(input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
    int n;
    n = 0;
    while (!req_ready_o && n < 10) begin tick(); n++; end
    drive(1'b1, we, f3, a, wd);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    n = 0;
    while (q.size() > 0 && n < 10) begin tick(); n++; end
    chk("timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic rnd(output bit we, output logic [2:0] f3, output logic [31:0] a,
                     output logic [31:0] wd);
    logic [31:0] odd [6];
    odd[0] = 32'd0; odd[1] = DB - 1; odd[2] = DB + 32'd4096;
    odd[3] = MB + 32'd4; odd[4] = MB - 1; odd[5] = 32'hFFFF_FFFF;
    case ($urandom % 8)
      0, 1, 2, 3: a = DB + 32'($urandom % 64);
      4, 5:       a = MB + 32'($urandom % 4);
      6:          a = odd[$urandom % 6];
      default:    a = DB + 32'd4092 + 32'($urandom % 4);
    endcase
    we = 1'($urandom % 2);
    f3 = 3'($urandom % 8);
    wd = $urandom;
  endtask

  task automatic rnd_phase(input int cycles, input int pct_valid);
    bit we;
    logic [2:0] f3;
    logic [31:0] a, wd;
    int n;
    fifo_rdata_i = 8'($urandom);
    for (int i = 0; i < cycles; i++) begin
      rnd(we, f3, a, wd);
      drive(($urandom % 100) < pct_valid, we, f3, a, wd);
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    n = 0;
    while (q.size() > 0 && n < 10) begin tick(); n++; end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rstn_i = 1'b0;
    fifo_rdata_i = 8'd0;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #12;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_fault", 32'(rsp_fault_o), 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_fifo", 32'({fifo_sel_o, fifo_rd_o, fifo_wr_o, fifo_addr_o, fifo_wdata_o}), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    for (int w = 0; w < 16; w++) req1(1'b1, 3'd2, DB + 32'(4 * w), $urandom);
    req1(1'b1, 3'd2, DB + 32'd4092, $urandom);

    req1(1'b1, 3'd2, DB + 32'd8, 32'hDEADBEEF);
    req1(1'b0, 3'd2, DB + 32'd8, 32'd0);
    chk("plan_lw", last_rd, 32'hDEADBEEF);

    req1(1'b1, 3'd2, DB, 32'h1122_3344);
    req1(1'b1, 3'd0, DB + 32'd1, 32'h0000_0080);
    req1(1'b0, 3'd0, DB + 32'd1, 32'd0);
    chk("plan_lb", last_rd, 32'hFFFF_FF80);
    req1(1'b0, 3'd4, DB + 32'd1, 32'd0);
    chk("plan_lbu", last_rd, 32'h0000_0080);
    req1(1'b0, 3'd2, DB, 32'd0);
    chk("plan_lw_lane", last_rd, 32'h1122_8044);

    req1(1'b0, 3'd1, DB + 32'd3, 32'd0);
    chk("plan_fault_h", 32'(last_fault), 32'd1);
    req1(1'b0, 3'd2, DB + 32'd2, 32'd0);
    chk("plan_fault_w", 32'(last_fault), 32'd1);
    req1(1'b0, 3'd2, 32'd0, 32'd0);
    chk("plan_fault_oow", 32'(last_fault), 32'd1);
    req1(1'b1, 3'd4, DB + 32'd8, 32'hFF);
    chk("plan_fault_sbu", 32'(last_fault), 32'd1);
    req1(1'b0, 3'd2, DB + 32'd8, 32'd0);
    chk("plan_unchanged", last_rd, 32'hDEADBEEF);

    fifo_rdata_i = 8'hC3;
    req1(1'b1, 3'd0, MB + 32'd1, 32'h41);
    req1(1'b0, 3'd0, MB, 32'd0);
    chk("plan_mmio_lb", last_rd, 32'hFFFF_FFC3);
    req1(1'b0, 3'd4, MB, 32'd0);
    chk("plan_mmio_lbu", last_rd, 32'h0000_00C3);
    req1(1'b0, 3'd1, MB, 32'd0);
    chk("plan_mmio_h", 32'(last_fault), 32'd1);

    rnd_phase(90, 100);
    rnd_phase(400, 66);

    // Reset while a load is in ACCESS
    while (!req_ready_o) tick();
    drive(1'b1, 1'b0, 3'd2, DB + 32'd8, 32'd0);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #1 rstn_i = 1'b0;
    #1;
    chk("mid_ready", 32'(req_ready_o), 32'd1);
    chk("mid_valid", 32'(rsp_valid_o), 32'd0);
    chk("mid_rdata", rsp_rdata_o, 32'd0);
    chk("mid_fifo", 32'({fifo_sel_o, fifo_rd_o, fifo_wr_o, fifo_addr_o, fifo_wdata_o}), 32'd0);
    q.delete();
    tick();
    tick();
    rstn_i = 1'b1;
    req1(1'b0, 3'd2, DB + 32'd8, 32'd0);
    chk("post_rst_fault", 32'(last_fault), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
